key_debounce_irq_ctrl: RTL and testbench

Avalon-MM slave controller for the push-button key inputs. It synchronises and debounces each key, holds the stable key state, and captures press (falling) edges into a sticky register. It raises a maskable interrupt toward the Nios II processor. It replaces the bare key input port on the system interconnect, so software sees clean, event-driven key data instead of polling raw, bouncing pins.

---
 rtl/key_debounce_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_key_debounce_irq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: per-key synchroniser and debouncer, sticky
// press capture with write-one-to-clear, and a maskable level interrupt.
module key_debounce_irq_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic {STABLE = 1'b0, SETTLING = 1'b1} deb_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] press, clr;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  deb_state_e       state_q [WIDTH];
  deb_state_e       state_d [WIDTH];
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  // Keys idle high, so the synchroniser powers up in the released state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        STABLE:   if (sync_q[i] != deb_q[i]) state_d[i] = SETTLING;
        SETTLING: if ((sync_q[i] == deb_q[i]) || (cnt_q[i] == CNT_LAST)) state_d[i] = STABLE;
        default:  state_d[i] = STABLE;
      endcase
    end
  end

  // Any edge where the synchronised level matches the accepted one restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      case (state_q[i])
        STABLE: begin
          if (sync_q[i] != deb_q[i]) cnt_d[i] = CNT_W'(1);
        end
        SETTLING: begin
          if (sync_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign wr_en        = chipselect && !write_n;
  assign press        = deb_q & ~deb_d;
  assign clr          = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // A press accepted on the same edge as a clear keeps the bit set.
  always_comb begin
    mask_d = (wr_en && (address == 2'd2)) ? writedata[WIDTH-1:0] : mask_q;
    edge_d = (edge_q & ~clr) | press;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = 32'(deb_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(edge_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_debounce_irq_ctrl.sv
// Bench for key_debounce_irq_ctrl: directed scenarios with literal expectations,
// then random key bouncing and bus traffic checked cycle by cycle against a model.
module tb_key_debounce_irq_ctrl;

  localparam int WIDTH = 3;
  localparam int DC    = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] inPort;
  logic [1:0]       address;
  logic             chipselect;
  logic             writeN;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  int nCompared = 0;
  int nMismatch = 0;

  key_debounce_irq_ctrl #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_port(inPort), .address(address),
    .chipselect(chipselect), .write_n(writeN), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a key's accepted level flips once the last DC synchronised samples
  // all disagree with it; the synchronised sample is the pin two edges ago.
  logic [WIDTH-1:0] mPipe1, mPipe2, mDeb, mMask, mEdge;
  logic [WIDTH-1:0] mHist [DC];
  logic [31:0]      mRead;
  logic             expIrq;

  always @(posedge clk or posedge reset) begin
    logic [WIDTH-1:0] s, newDeb, clrBits;
    logic             allDiff;
    if (reset) begin
      mPipe1 = '1; mPipe2 = '1; mDeb = '1; mMask = '0; mEdge = '0; mRead = '0;
      for (int j = 0; j < DC; j++) mHist[j] = '1;
    end else begin
      case (address)
        2'd0:    mRead = 32'(mDeb);
        2'd2:    mRead = 32'(mMask);
        2'd3:    mRead = 32'(mEdge);
        default: mRead = 32'd0;
      endcase
      s = mPipe2;
      for (int j = DC - 1; j > 0; j--) mHist[j] = mHist[j-1];
      mHist[0] = s;
      newDeb = mDeb;
      for (int i = 0; i < WIDTH; i++) begin
        allDiff = 1'b1;
        for (int j = 0; j < DC; j++) if (mHist[j][i] == mDeb[i]) allDiff = 1'b0;
        if (allDiff) newDeb[i] = s[i];
      end
      clrBits = '0;
      if (chipselect && !writeN && address == 2'd2) mMask = writedata[WIDTH-1:0];
      if (chipselect && !writeN && address == 2'd3) clrBits = writedata[WIDTH-1:0];
      mEdge  = (mEdge & ~clrBits) | (mDeb & ~newDeb);
      mDeb   = newDeb;
      mPipe2 = mPipe1;
      mPipe1 = inPort;
    end
  end

  assign expIrq = |(mEdge & mMask);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_readdata", readdata, mRead);
      checkOutput("model_irq", {31'd0, irq}, {31'd0, expIrq});
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] keys, input logic [1:0] addr,
                               input logic cs, input logic wn, input logic [31:0] wd);
    inPort     = keys;
    address    = addr;
    chipselect = cs;
    writeN     = wn;
    writedata  = wd;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] keys;
    reset = 1'b1;
    applyStimulus(3'b111, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(3);
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    waitCycles(1);
    checkOutput("data_after_rst", readdata, 32'h7);
    applyStimulus(3'b111, 2'd2, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("mask_after_rst", readdata, 32'h0);
    applyStimulus(3'b111, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("edgecap_after_rst", readdata, 32'h0);

    // Clean press of key 0: accepted on the 10th edge after the change.
    applyStimulus(3'b110, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(10);
    checkOutput("press0_not_yet", readdata, 32'h7);
    waitCycles(1);
    checkOutput("press0_accepted", readdata, 32'h6);
    applyStimulus(3'b110, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("press0_capture", readdata, 32'h1);
    checkOutput("press0_irq_masked", {31'd0, irq}, 32'd0);

    // Key 1 bounces: low 5, high 1, then low until accepted.
    applyStimulus(3'b100, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(5);
    applyStimulus(3'b110, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    applyStimulus(3'b100, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(10);
    checkOutput("bounce_not_yet", readdata, 32'h6);
    waitCycles(1);
    checkOutput("bounce_accepted", readdata, 32'h4);
    applyStimulus(3'b100, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("bounce_capture", readdata, 32'h3);

    // Mask, W1C and a zero write to EDGECAP.
    applyStimulus(3'b100, 2'd2, 1'b1, 1'b0, 32'h1);
    waitCycles(1);
    applyStimulus(3'b100, 2'd0, 1'b0, 1'b1, 32'd0);
    checkOutput("irq_after_mask", {31'd0, irq}, 32'd1);
    applyStimulus(3'b100, 2'd3, 1'b1, 1'b0, 32'h1);
    waitCycles(1);
    applyStimulus(3'b100, 2'd3, 1'b0, 1'b1, 32'd0);
    checkOutput("irq_after_w1c", {31'd0, irq}, 32'd0);
    applyStimulus(3'b100, 2'd3, 1'b1, 1'b0, 32'h0);
    waitCycles(1);
    applyStimulus(3'b100, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("w1c_zero_noop", readdata, 32'h2);

    // Clear of bit 2 lands on the edge the key 2 press is accepted.
    applyStimulus(3'b100, 2'd2, 1'b1, 1'b0, 32'h4);
    waitCycles(1);
    applyStimulus(3'b000, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(9);
    applyStimulus(3'b000, 2'd3, 1'b1, 1'b0, 32'h4);
    waitCycles(1);
    applyStimulus(3'b000, 2'd3, 1'b0, 1'b1, 32'd0);
    checkOutput("set_wins_irq", {31'd0, irq}, 32'd1);
    waitCycles(1);
    checkOutput("set_wins_edgecap", readdata, 32'h6);

    // Releases capture nothing.
    applyStimulus(3'b000, 2'd3, 1'b1, 1'b0, 32'h7);
    waitCycles(1);
    applyStimulus(3'b111, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(12);
    applyStimulus(3'b111, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("release_no_capture", readdata, 32'h0);

    // Reset while key 1 is mid-debounce, key still held afterwards.
    applyStimulus(3'b101, 2'd0, 1'b0, 1'b1, 32'd0);
    waitCycles(7);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    checkOutput("midrst_readdata", readdata, 32'h0);
    checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
    waitCycles(1);
    checkOutput("midrst_data", readdata, 32'h7);
    waitCycles(9);
    checkOutput("midrst_not_yet", readdata, 32'h7);
    waitCycles(1);
    checkOutput("midrst_accepted", readdata, 32'h5);
    applyStimulus(3'b101, 2'd3, 1'b0, 1'b1, 32'd0);
    waitCycles(1);
    checkOutput("midrst_capture", readdata, 32'h2);

    // Random bouncing keys and random bus traffic, checked by the model.
    $display("[TB] random phase");
    keys = 3'b111;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0)
        applyStimulus(keys, 2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)),
                      $urandom());
      else
        applyStimulus(keys, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1,
                      $urandom());
      waitCycles(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
